// File: rtl/fifo_wr_arb_if.sv
// Bundle of requester, FIFO-side and status signals for the FIFO write-port arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters'/FIFO's view.
interface fifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [WIDTH-1:0]        fifo_din;
  logic [$clog2(NREQ)-1:0] gnt_id;
  logic                    busy;
  logic [15:0]             xfer_cnt;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, gnt_id, busy, xfer_cnt
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, gnt_id, busy, xfer_cnt
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// A grant lasts up to BURST accepted words, or until its owner runs out of data.
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arb_if.master     bus
);
  localparam int GW = $clog2(NREQ);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   gnt, gnt_nx, last_gnt, last_gnt_nx, winner;
  logic [BW-1:0]   beat, beat_nx;
  logic [15:0]     cnt;
  logic [NREQ-1:0] ready;
  logic            any_valid, busy, wr_en, burst_done, release_gnt;

  // Search starts just past the previous owner: last_gnt when idle, gnt on handover.
  always_comb begin
    logic [GW-1:0] base;
    logic          found;
    int            idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    base   = (state == GRANT) ? gnt : last_gnt;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(base) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_valid   = |bus.req_valid;
  assign busy        = (state == GRANT);
  assign wr_en       = busy & bus.req_valid[gnt] & ~bus.fifo_full;
  assign burst_done  = wr_en && (beat == BW'(BURST - 1));
  assign release_gnt = busy && (!bus.req_valid[gnt] || burst_done);

  always_comb begin
    ready = '0;
    if (busy && !bus.fifo_full)
      ready[gnt] = 1'b1;
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_din   = busy ? bus.req_data[int'(gnt)*WIDTH +: WIDTH] : '0;
  assign bus.gnt_id     = gnt;
  assign bus.busy       = busy;
  assign bus.xfer_cnt   = cnt;

  // Handover goes straight to the next winner so back-to-back grants have no bubble.
  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    last_gnt_nx = last_gnt;
    beat_nx     = beat;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nx = GRANT;
          gnt_nx   = winner;
          beat_nx  = '0;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          last_gnt_nx = gnt;
          beat_nx     = '0;
          if (any_valid)
            gnt_nx = winner;
          else
            state_nx = IDLE;
        end else if (wr_en) begin
          beat_nx = beat + BW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= GW'(NREQ - 1);
      beat     <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      last_gnt <= last_gnt_nx;
      beat     <= beat_nx;
      if (wr_en)
        cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed-vector bench for fifo_wr_arb (NREQ=4, WIDTH=8, BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_fifo_wr_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  fifo_wr_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    bus.fifo_full = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    vectors++;
    if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en got %b want 0", bus.fifo_wr_en); end
    vectors++;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 0000", bus.req_ready); end
    vectors++;
    if (bus.fifo_din !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_din got %h want 00", bus.fifo_din); end
    vectors++;
    if (bus.gnt_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_gnt got %0d want 0", bus.gnt_id); end
    vectors++;
    if (bus.xfer_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_xfer_cnt got %0d want 0", bus.xfer_cnt); end
    bus.req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    logic [7:0] d;
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h0000A100;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_idle busy=%b wr_en=%b want 0/0", bus.busy, bus.fifo_wr_en);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      d = 8'hA1 + 8'(i);
      bus.req_data = {16'h0000, d, 8'h00};
      #1;
      vectors++;
      if (bus.fifo_wr_en !== 1'b1 || bus.gnt_id !== 2'd1 || bus.fifo_din !== d || bus.req_ready !== 4'b0010) begin
        miscompares++;
        $display("[TB] FAIL single_beat%0d wr_en=%b gnt=%0d din=%h ready=%b want 1/1/%h/0010",
                 i, bus.fifo_wr_en, bus.gnt_id, bus.fifo_din, bus.req_ready, d);
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    #1;
    vectors++;
    if (bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL single_drop wr_en=%b busy=%b want 0/1", bus.fifo_wr_en, bus.busy);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_release busy=%b want 0", bus.busy); end
    vectors++;
    if (bus.xfer_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL single_xfer_cnt got %0d want 3", bus.xfer_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg;
    logic [7:0] ed;
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    #1;
    vectors++;
    if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_idle wr_en=%b want 0", bus.fifo_wr_en); end
    tick();
    for (int c = 0; c < 16; c++) begin
      eg = 2'(c / 4);
      ed = 8'h11 * (8'(eg) + 8'd1);
      vectors++;
      if (bus.fifo_wr_en !== 1'b1 || bus.gnt_id !== eg || bus.fifo_din !== ed) begin
        miscompares++;
        $display("[TB] FAIL rr_cycle%0d wr_en=%b gnt=%0d din=%h want 1/%0d/%h",
                 c + 1, bus.fifo_wr_en, bus.gnt_id, bus.fifo_din, eg, ed);
      end
      tick();
    end
    vectors++;
    if (bus.gnt_id !== 2'd0 || bus.fifo_wr_en !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rr_wrap gnt=%0d wr_en=%b want 0/1", bus.gnt_id, bus.fifo_wr_en);
    end
    vectors++;
    if (bus.xfer_cnt !== 16'd16) begin miscompares++; $display("[TB] FAIL rr_xfer_cnt got %0d want 16", bus.xfer_cnt); end
    bus.req_valid = '0;
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h00000055;
    tick();
    tick();
    tick();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000 || bus.gnt_id !== 2'd0 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL full_stall%0d wr_en=%b ready=%b gnt=%0d busy=%b want 0/0000/0/1",
                 i, bus.fifo_wr_en, bus.req_ready, bus.gnt_id, bus.busy);
      end
      tick();
    end
    bus.fifo_full = 1'b0;
    bus.req_valid = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (bus.fifo_wr_en !== 1'b1 || bus.gnt_id !== 2'd0) begin
        miscompares++; $display("[TB] FAIL full_resume%0d wr_en=%b gnt=%0d want 1/0", i, bus.fifo_wr_en, bus.gnt_id);
      end
      tick();
    end
    vectors++;
    if (bus.gnt_id !== 2'd1) begin miscompares++; $display("[TB] FAIL full_handover gnt=%0d want 1", bus.gnt_id); end
    vectors++;
    if (bus.xfer_cnt !== 16'd4) begin miscompares++; $display("[TB] FAIL full_xfer_cnt got %0d want 4", bus.xfer_cnt); end
    bus.req_valid = '0;
  endtask

  task automatic test_drop_wrap();
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h0022000A;
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd2 || bus.fifo_wr_en !== 1'b1) begin
      miscompares++; $display("[TB] FAIL drop_grant gnt=%0d wr_en=%b want 2/1", bus.gnt_id, bus.fifo_wr_en);
    end
    tick();
    tick();
    bus.req_valid = 4'b0001;
    #1;
    vectors++;
    if (bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL drop_cycle wr_en=%b busy=%b want 0/1", bus.fifo_wr_en, bus.busy);
    end
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd0 || bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'h0A) begin
      miscompares++;
      $display("[TB] FAIL drop_wrap gnt=%0d wr_en=%b din=%h want 0/1/0a", bus.gnt_id, bus.fifo_wr_en, bus.fifo_din);
    end
    vectors++;
    if (dut.last_gnt !== 2'd2) begin miscompares++; $display("[TB] FAIL drop_last_gnt got %0d want 2", dut.last_gnt); end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL midrst_outputs busy=%b wr_en=%b ready=%b want 0/0/0000", bus.busy, bus.fifo_wr_en, bus.req_ready);
    end
    vectors++;
    if (bus.xfer_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL midrst_xfer_cnt got %0d want 0", bus.xfer_cnt); end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_idle busy=%b want 0", bus.busy); end
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd0 || bus.fifo_wr_en !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midrst_first gnt=%0d wr_en=%b want 0/1", bus.gnt_id, bus.fifo_wr_en);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_xfer_wrap();
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'd65535;
    exp_cnt[1] = 16'd0;
    exp_cnt[2] = 16'd1;
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    tick();
    repeat (65534) tick();
    vectors++;
    if (bus.xfer_cnt !== 16'd65534) begin miscompares++; $display("[TB] FAIL wrap_preload got %0d want 65534", bus.xfer_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.xfer_cnt !== exp_cnt[i]) begin
        miscompares++; $display("[TB] FAIL wrap_step%0d got %0d want %0d", i, bus.xfer_cnt, exp_cnt[i]);
      end
    end
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_drop_wrap();
    test_reset_mid();
    test_xfer_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
